// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types and parameter ranges for the serial pattern detector
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HIT  = 2'd2
  } statetype;

  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 32;
  localparam int CNT_W_MIN = 1;
  localparam int CNT_W_MAX = 32;

endpackage

// File: rtl/seq_detector_cfg_sat_counter.sv
// rtl/seq_detector_cfg_sat_counter.sv - saturating up-counter with priority clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  // Clear beats increment; the count parks at all-ones once it gets there.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      r_q <= '0;
    end else if (inc && (r_q != {W{1'b1}})) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/seq_detector_cfg.sv
// rtl/seq_detector_cfg.sv - runtime-programmable serial pattern detector with match counter
module seq_detector_cfg
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic             overlap,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr_count,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             armed,
  output logic             cfg_err
);

  statetype         r_state;
  logic [PAT_W-1:0] r_hist;
  logic [LEN_W-1:0] r_fill;
  logic [PAT_W-1:0] r_pattern;
  logic [LEN_W-1:0] r_len;
  logic             r_cfg_err;

  statetype         w_state_n;
  logic [PAT_W-1:0] w_hist_n;
  logic [LEN_W-1:0] w_fill_n;
  logic [PAT_W-1:0] w_pattern_n;
  logic [LEN_W-1:0] w_len_n;
  logic [PAT_W-1:0] w_shift;
  logic [LEN_W-1:0] w_fill_inc;
  logic [PAT_W:0]   w_mask_wide;
  logic [PAT_W-1:0] w_mask;
  logic             w_len_ok;
  logic             w_accept;
  logic             w_match_det;
  logic             w_cfg_err_n;

  // Next-state, history update and masked compare against the loaded pattern.
  always_comb begin
    w_state_n   = r_state;
    w_hist_n    = r_hist;
    w_fill_n    = r_fill;
    w_pattern_n = r_pattern;
    w_len_n     = r_len;
    w_cfg_err_n = 1'b0;

    w_len_ok    = (len_in != '0) && (len_in <= LEN_W'(PAT_W));
    w_accept    = in_valid && (r_state != IDLE) && !load;

    // Candidate values if this cycle's bit is taken; fill never runs past len.
    w_shift     = {r_hist[PAT_W-2:0], in_bit};
    w_fill_inc  = (r_fill >= r_len) ? r_len : (r_fill + LEN_W'(1));

    // Computed one bit wider so len == PAT_W yields an all-ones mask.
    w_mask_wide = ((PAT_W + 1)'(1) << r_len) - (PAT_W + 1)'(1);
    w_mask      = w_mask_wide[PAT_W-1:0];

    w_match_det = w_accept && (w_fill_inc == r_len) &&
                  (((w_shift ^ r_pattern) & w_mask) == '0);

    if (load) begin
      if (w_len_ok) begin
        w_pattern_n = pattern_in;
        w_len_n     = len_in;
        w_hist_n    = '0;
        w_fill_n    = '0;
        w_state_n   = SCAN;
      end else begin
        w_cfg_err_n = 1'b1;
        if (r_state == HIT) w_state_n = SCAN;
      end
    end else if (w_accept) begin
      if (w_match_det) begin
        w_state_n = HIT;
        if (overlap) begin
          w_hist_n = w_shift;
          w_fill_n = w_fill_inc;
        end else begin
          w_hist_n = '0;
          w_fill_n = '0;
        end
      end else begin
        w_state_n = SCAN;
        w_hist_n  = w_shift;
        w_fill_n  = w_fill_inc;
      end
    end else if (r_state == HIT) begin
      w_state_n = SCAN;
    end
  end

  // Register the detector state; reset forgets the pattern so a reload is required.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_hist    <= '0;
      r_fill    <= '0;
      r_pattern <= '0;
      r_len     <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_hist    <= w_hist_n;
      r_fill    <= w_fill_n;
      r_pattern <= w_pattern_n;
      r_len     <= w_len_n;
      r_cfg_err <= w_cfg_err_n;
    end
  end

  sat_counter #(.W(CNT_W)) u_count (
    .clock (clock),
    .reset (reset),
    .clr   (clr_count),
    .inc   (w_match_det),
    .q     (match_count)
  );

  assign match   = (r_state == HIT);
  assign armed   = (r_state != IDLE);
  assign cfg_err = r_cfg_err;

endmodule

// File: tb/tb_seq_detector_cfg.sv
// tb/tb_seq_detector_cfg.sv - directed self-checking bench for seq_detector_cfg
module tb_seq_detector_cfg;

  localparam int PAT_W = 8;
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             clock = 1'b0;
  logic             reset;
  logic             load;
  logic [PAT_W-1:0] pattern_in;
  logic [LEN_W-1:0] len_in;
  logic             overlap;
  logic             in_valid;
  logic             in_bit;
  logic             clr_count;

  logic             match_a, armed_a, cfg_err_a;
  logic [7:0]       count_a;
  logic             match_b, armed_b, cfg_err_b;
  logic [1:0]       count_b;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  seq_detector_cfg #(.PAT_W(PAT_W), .CNT_W(8)) dut_a (
    .clock(clock), .reset(reset), .load(load), .pattern_in(pattern_in),
    .len_in(len_in), .overlap(overlap), .in_valid(in_valid), .in_bit(in_bit),
    .clr_count(clr_count), .match(match_a), .match_count(count_a),
    .armed(armed_a), .cfg_err(cfg_err_a)
  );

  seq_detector_cfg #(.PAT_W(PAT_W), .CNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .load(load), .pattern_in(pattern_in),
    .len_in(len_in), .overlap(overlap), .in_valid(in_valid), .in_bit(in_bit),
    .clr_count(clr_count), .match(match_b), .match_count(count_b),
    .armed(armed_b), .cfg_err(cfg_err_b)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    load = 0; in_valid = 0; in_bit = 0; clr_count = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic do_load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l);
    load = 1; pattern_in = p; len_in = l;
    tick();
    load = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (match_a !== 1'b0 || armed_a !== 1'b0 || cfg_err_a !== 1'b0 || count_a !== 8'd0) begin
      errors++;
      $display("FAIL reset: match=%b armed=%b cfg_err=%b count=%0d, want 0 0 0 0",
               match_a, armed_a, cfg_err_a, count_a);
    end
  endtask

  task automatic test_overlap();
    logic [6:0] bits = 7'b1011011;
    logic [6:0] exp  = 7'b0001001;
    overlap = 1;
    do_load(8'b0000_1011, 4'd4);
    checks++;
    if (armed_a !== 1'b1) begin
      errors++; $display("FAIL overlap_armed: armed=%b want 1", armed_a);
    end
    for (int i = 6; i >= 0; i--) begin
      in_valid = 1; in_bit = bits[i];
      tick();
      checks++;
      if (match_a !== exp[i]) begin
        errors++; $display("FAIL overlap_match bit%0d: match=%b want %b", 7 - i, match_a, exp[i]);
      end
    end
    in_valid = 0;
    checks++;
    if (count_a !== 8'd2) begin
      errors++; $display("FAIL overlap_count: count=%0d want 2", count_a);
    end
  endtask

  task automatic test_no_overlap();
    logic [6:0] bits = 7'b1011011;
    logic [6:0] exp  = 7'b0001000;
    overlap = 0;
    clr_count = 1;
    do_load(8'b0000_1011, 4'd4);
    clr_count = 0;
    for (int i = 6; i >= 0; i--) begin
      in_valid = 1; in_bit = bits[i];
      tick();
      checks++;
      if (match_a !== exp[i]) begin
        errors++; $display("FAIL nooverlap_match bit%0d: match=%b want %b", 7 - i, match_a, exp[i]);
      end
    end
    in_valid = 0;
    checks++;
    if (count_a !== 8'd1) begin
      errors++; $display("FAIL nooverlap_count: count=%0d want 1", count_a);
    end
  endtask

  task automatic test_len1_gaps();
    logic [5:0] vld = 6'b110101;
    logic [5:0] bts = 6'b110011;
    logic [5:0] exp = 6'b110001;
    overlap = 1;
    clr_count = 1;
    do_load(8'h01, 4'd1);
    clr_count = 0;
    for (int i = 5; i >= 0; i--) begin
      in_valid = vld[i]; in_bit = bts[i];
      tick();
      checks++;
      if (match_a !== exp[i]) begin
        errors++; $display("FAIL len1_match step%0d: match=%b want %b", 6 - i, match_a, exp[i]);
      end
    end
    in_valid = 0;
    checks++;
    if (count_a !== 8'd3) begin
      errors++; $display("FAIL len1_count: count=%0d want 3", count_a);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_b;
    do_reset();
    overlap = 1;
    do_load(8'h01, 4'd1);
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1; in_bit = 1;
      tick();
      exp_b = (i > 3) ? 2'd3 : 2'(i);
      checks++;
      if (match_b !== 1'b1 || count_b !== exp_b) begin
        errors++;
        $display("FAIL sat_step%0d: match=%b count=%0d want 1 %0d", i, match_b, count_b, exp_b);
      end
    end
    checks++;
    if (count_a !== 8'd5) begin
      errors++; $display("FAIL sat_wide_count: count=%0d want 5", count_a);
    end
    clr_count = 1; in_valid = 1; in_bit = 1;
    tick();
    clr_count = 0; in_valid = 0;
    checks++;
    if (match_b !== 1'b1 || count_b !== 2'd0 || count_a !== 8'd0) begin
      errors++;
      $display("FAIL clr_vs_match: match=%b count_b=%0d count_a=%0d want 1 0 0", match_b, count_b, count_a);
    end
  endtask

  task automatic test_cfg_err();
    do_reset();
    do_load(8'hFF, 4'd0);
    checks++;
    if (cfg_err_a !== 1'b1 || armed_a !== 1'b0) begin
      errors++; $display("FAIL cfgerr_idle: cfg_err=%b armed=%b want 1 0", cfg_err_a, armed_a);
    end
    tick();
    checks++;
    if (cfg_err_a !== 1'b0) begin
      errors++; $display("FAIL cfgerr_pulse: cfg_err=%b want 0", cfg_err_a);
    end
    overlap = 1;
    do_load(8'h01, 4'd1);
    do_load(8'h00, 4'(PAT_W + 1));
    checks++;
    if (cfg_err_a !== 1'b1 || armed_a !== 1'b1) begin
      errors++; $display("FAIL cfgerr_armed: cfg_err=%b armed=%b want 1 1", cfg_err_a, armed_a);
    end
    in_valid = 1; in_bit = 1;
    tick();
    checks++;
    if (match_a !== 1'b1) begin
      errors++; $display("FAIL cfgerr_keep_pattern: match=%b want 1", match_a);
    end
    // Load with a valid bit: that bit must not count toward the new pattern.
    in_valid = 1; in_bit = 1;
    do_load(8'b11, 4'd2);
    in_valid = 1; in_bit = 1;
    tick();
    checks++;
    if (match_a !== 1'b0) begin
      errors++; $display("FAIL load_drop_first: match=%b want 0", match_a);
    end
    tick();
    in_valid = 0;
    checks++;
    if (match_a !== 1'b1) begin
      errors++; $display("FAIL load_drop_second: match=%b want 1", match_a);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] bits = 4'b1011;
    logic [3:0] exp  = 4'b0001;
    overlap = 1;
    do_load(8'b1011, 4'd4);
    for (int i = 3; i >= 1; i--) begin
      in_valid = 1; in_bit = bits[i];
      tick();
    end
    do_reset();
    checks++;
    if (armed_a !== 1'b0 || count_a !== 8'd0 || match_a !== 1'b0) begin
      errors++; $display("FAIL midreset: armed=%b count=%0d match=%b want 0 0 0", armed_a, count_a, match_a);
    end
    in_valid = 1; in_bit = 1;
    tick();
    checks++;
    if (match_a !== 1'b0 || armed_a !== 1'b0) begin
      errors++; $display("FAIL midreset_idle: match=%b armed=%b want 0 0", match_a, armed_a);
    end
    in_valid = 0;
    do_load(8'b1011, 4'd4);
    for (int i = 3; i >= 0; i--) begin
      in_valid = 1; in_bit = bits[i];
      tick();
      checks++;
      if (match_a !== exp[i]) begin
        errors++; $display("FAIL midreset_reload bit%0d: match=%b want %b", 4 - i, match_a, exp[i]);
      end
    end
    in_valid = 0;
  endtask

  initial begin
    pattern_in = '0; len_in = '0; overlap = 1'b1; reset = 1'b1;
    idle_inputs();
    test_reset();
    test_overlap();
    test_no_overlap();
    test_len1_gaps();
    test_saturate();
    test_cfg_err();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
